preadder_issue_sched: RTL and testbench
=======================================

Name: preadder_issue_sched

Overview:
- Operand issue scheduler sitting directly upstream of the preadder in the BN254 datapath.
- Buffers operand beats per thread: X, Y (redundant_poly_L3), mode1, mode2.
- Selects one beat per cycle round-robin across the 4 threads.
- Drives the preadder's X/Y/mode1/mode2/thread inputs from registers. Idle cycles never corrupt the preadder's per-thread delay registers.

Parameters:
- DEPTH, 4, entries per thread FIFO; power of two, 2..16.
- W, $bits(redundant_poly_L3), width of one operand field; not overridden.

Ports:
- clk  input  1  clock
- rstn  input  1  reset; asynchronous, active-low
- in_valid  input  1  push request
- in_ready  output  1  FIFO addressed by in_thread is not full
- in_thread  input  2  target thread of push
- in_X  input  W  operand X (redundant_poly_L3)
- in_Y  input  W  operand Y (redundant_poly_L3)
- in_mode1  input  2  mode1 for this beat
- in_mode2  input  2  mode2 for this beat
- stall  input  1  downstream hold; freezes issue
- X  output  W  to preadder X
- Y  output  W  to preadder Y
- mode1  output  2  to preadder mode1
- mode2  output  2  to preadder mode2
- thread  output  2  to preadder thread
- out_valid  output  1  current output beat is a real issue
- occ  output  4*($clog2(DEPTH)+1)  per-thread occupancy, thread 0 in LSBs

Behaviour:
- Reset (rstn low, async):
  - all FIFOs empty; occ=0; rr pointer=0.
  - X=Y=0, mode1=mode2=2'b00, thread=0, out_valid=0.
  - Reset mid-operation discards all buffered beats.
- Push:
  - Accepted at an edge when in_valid && in_ready. Beat goes to the tail of FIFO[in_thread].
  - in_ready = (occ[in_thread] != DEPTH). It depends only on current occupancy: no credit for a same-cycle pop.
  - in_valid with in_ready=0 is ignored. Upstream must hold the beat.
- Eligibility:
  - A beat pushed at edge t may be issued no earlier than edge t+1, so it appears on the outputs after edge t+1.
  - No bypass from input to output.
- Arbitration, evaluated each edge with stall=0:
  - Search threads rr, rr+1, rr+2, rr+3 (mod 4). Pick the first with a non-empty FIFO.
  - Pop its head and register it to X, Y, mode1, mode2, thread; out_valid<=1.
  - rr <= picked+1 (mod 4).
- Bubble (stall=0, all FIFOs empty):
  - out_valid<=0; mode1<=00; mode2<=00.
  - X, Y, thread hold the last issued values. The preadder rewrites that thread's delay registers with identical data, so they are preserved.
  - rr unchanged.
- Stall=1:
  - No pop. All outputs, including out_valid, hold. rr holds.
  - Pushes continue normally.
- Simultaneous push and pop on the same thread:
  - Both occur; occ unchanged.
  - A push into a full FIFO is impossible because in_ready=0.
- FIFO pointers wrap modulo DEPTH. occ counts 0..DEPTH inclusive.
- Per-thread order is strict FIFO. Cross-thread order follows round-robin only.
- Mode fields pass through unmodified; 2'b11 is issued as-is.

Test Plan:
- Reset, then push thread 2 beat {X=5, Y=7, mode1=01, mode2=10} at edge 1.
  - Outputs show X=5, Y=7, mode1=01, mode2=10, thread=2, out_valid=1 after edge 2.
  - out_valid=0 after edge 3; X=5, Y=7, thread=2 held; modes=00.
- Preload 2 beats in each of threads 0–3 (X=16*t+i), stall=1, then release stall.
  - Issue order is threads 0,1,2,3,0,1,2,3 with i=0 then i=1 per thread.
  - Exactly 8 valid cycles, back-to-back.
- Fill thread 1 with DEPTH=4 beats.
  - in_ready=0 while in_thread=1, and a 5th push is dropped.
  - in_ready=1 for in_thread=0 in the same cycle.
  - After one pop, the push is accepted; occ[1]=4.
- Assert stall for 3 cycles mid-stream.
  - Outputs frozen, including out_valid=1.
  - Pushes still raise occ.
  - Issue resumes with the next round-robin thread; no beat lost or duplicated.
- Push to thread 3 on every cycle while it is the only active thread.
  - Steady state issues one beat per cycle; occ[3] stays constant.
  - Data order matches push order.
- Deassert rstn asynchronously mid-burst with occ={2,1,0,3}.
  - Outputs go to 0 immediately, before the next clk edge.
  - occ=0; no issue after rstn rises until new pushes arrive.

Source files
------------

// File: rtl/preadder_issue_sched.sv
// Operand issue scheduler feeding the BN254 preadder.
// Four per-thread operand FIFOs; one beat issued per cycle, round-robin.
// Idle cycles keep X/Y/thread and zero the modes so the preadder rewrites
// the last thread's delay registers with identical data.
// W is the width of one redundant_poly_L3 operand field.
module preadder_issue_sched #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_thread,
  input  logic [W-1:0]                    in_X,
  input  logic [W-1:0]                    in_Y,
  input  logic [1:0]                      in_mode1,
  input  logic [1:0]                      in_mode2,
  input  logic                            stall,
  output logic [W-1:0]                    X,
  output logic [W-1:0]                    Y,
  output logic [1:0]                      mode1,
  output logic [1:0]                      mode2,
  output logic [1:0]                      thread,
  output logic                            out_valid,
  output logic [4*($clog2(DEPTH)+1)-1:0]  occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 2*W + 4;

  logic [BW-1:0] mem_q  [4][DEPTH];
  logic [AW-1:0] wptr_q [4];
  logic [AW-1:0] rptr_q [4];
  logic [CW-1:0] occ_q  [4];
  logic [1:0]    rr_q;

  logic [W-1:0]  x_q, y_q;
  logic [1:0]    mode1_q, mode2_q, thread_q;
  logic          out_valid_q;

  logic          push, pop;
  logic [1:0]    pick;
  logic          pick_valid;
  logic [BW-1:0] head;

  // Push acceptance only looks at current occupancy; a same-cycle pop gives no credit.
  assign in_ready = (occ_q[in_thread] != CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Round-robin search starting at rr; descending loop so the nearest thread wins.
  always_comb begin
    logic [1:0] idx;
    pick       = rr_q;
    pick_valid = 1'b0;
    idx        = rr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (occ_q[idx] != '0) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign pop  = !stall && pick_valid;
  assign head = mem_q[pick][rptr_q[pick]];

  // Operand storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[in_thread][wptr_q[in_thread]] <= {in_X, in_Y, in_mode1, in_mode2};
  end

  // Per-thread pointers and occupancy; a push and pop on one thread cancel in occ.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < 4; t++) begin
        wptr_q[t] <= '0;
        rptr_q[t] <= '0;
        occ_q[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < 4; t++) begin
        logic push_t, pop_t;
        push_t = push && (in_thread == 2'(t));
        pop_t  = pop && (pick == 2'(t));
        if (push_t) wptr_q[t] <= wptr_q[t] + AW'(1);
        if (pop_t)  rptr_q[t] <= rptr_q[t] + AW'(1);
        if (push_t && !pop_t)      occ_q[t] <= occ_q[t] + CW'(1);
        else if (pop_t && !push_t) occ_q[t] <= occ_q[t] - CW'(1);
      end
    end
  end

  // Issue register: pop on a pick, bubble (modes zeroed, X/Y/thread held) when empty, freeze on stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q         <= '0;
      y_q         <= '0;
      mode1_q     <= 2'b00;
      mode2_q     <= 2'b00;
      thread_q    <= 2'd0;
      out_valid_q <= 1'b0;
      rr_q        <= 2'd0;
    end else if (!stall) begin
      if (pick_valid) begin
        {x_q, y_q, mode1_q, mode2_q} <= head;
        thread_q    <= pick;
        out_valid_q <= 1'b1;
        rr_q        <= pick + 2'd1;
      end else begin
        mode1_q     <= 2'b00;
        mode2_q     <= 2'b00;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign X         = x_q;
  assign Y         = y_q;
  assign mode1     = mode1_q;
  assign mode2     = mode2_q;
  assign thread    = thread_q;
  assign out_valid = out_valid_q;

  // Occupancy export, thread 0 in the LSBs.
  always_comb begin
    occ = '0;
    for (int t = 0; t < 4; t++) occ[t*CW +: CW] = occ_q[t];
  end

endmodule

// File: tb/tb_preadder_issue_sched.sv
// Directed bench for preadder_issue_sched (DEPTH=4, W=32).
module tb_preadder_issue_sched;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_thread = 2'd0;
  logic [W-1:0]  in_X = '0, in_Y = '0;
  logic [1:0]    in_mode1 = 2'd0, in_mode2 = 2'd0;
  logic          stall = 1'b0;
  logic [W-1:0]  X, Y;
  logic [1:0]    mode1, mode2, thread;
  logic          out_valid;
  logic [11:0]   occ;

  int errors = 0;
  int checks = 0;

  preadder_issue_sched #(.DEPTH(4), .W(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_thread(in_thread), .in_X(in_X), .in_Y(in_Y), .in_mode1(in_mode1),
    .in_mode2(in_mode2), .stall(stall), .X(X), .Y(Y), .mode1(mode1),
    .mode2(mode2), .thread(thread), .out_valid(out_valid), .occ(occ)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] obs();
    return {out_valid, thread, mode1, mode2, X, Y};
  endfunction

  function automatic logic [70:0] beat(bit v, int t, int m1, int m2, int x, int y);
    return {v, 2'(t), 2'(m1), 2'(m2), 32'(x), 32'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int t, int x, int y, int m1, int m2);
    in_valid  = v;
    in_thread = 2'(t);
    in_X      = 32'(x);
    in_Y      = 32'(y);
    in_mode1  = 2'(m1);
    in_mode2  = 2'(m2);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    rstn     = 1'b0;
    #2;
    rstn     = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    checks++; if (obs() !== 71'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs()); end
    checks++; if (occ !== 12'd0) begin errors++; $display("FAIL reset_occ: got %h expected 0", occ); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    logic [70:0] e;
    do_reset();
    drive(1, 2, 5, 7, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", out_valid); end
    checks++; if (occ !== {3'd0, 3'd1, 3'd0, 3'd0}) begin errors++; $display("FAIL single_occ: got %h expected %h", occ, {3'd0, 3'd1, 3'd0, 3'd0}); end
    tick();
    e = beat(1, 2, 1, 2, 5, 7);
    checks++; if (obs() !== e) begin errors++; $display("FAIL single_issue: got %h expected %h", obs(), e); end
    tick();
    e = beat(0, 2, 0, 0, 5, 7);
    checks++; if (obs() !== e) begin errors++; $display("FAIL single_bubble: got %h expected %h", obs(), e); end
  endtask

  task automatic test_round_robin();
    logic [70:0] e;
    int t, i, x;
    do_reset();
    stall = 1'b1;
    for (int ii = 0; ii < 2; ii++)
      for (int tt = 0; tt < 4; tt++) begin
        drive(1, tt, 16*tt + ii, 16*tt + ii + 256, tt, ii);
        tick();
      end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (occ !== {3'd2, 3'd2, 3'd2, 3'd2}) begin errors++; $display("FAIL rr_preload_occ: got %h expected %h", occ, {3'd2, 3'd2, 3'd2, 3'd2}); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_stalled_valid: got %b expected 0", out_valid); end
    stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      t = k % 4;
      i = k / 4;
      x = 16*t + i;
      e = beat(1, t, t, i, x, x + 256);
      checks++; if (obs() !== e) begin errors++; $display("FAIL rr_issue_%0d: got %h expected %h", k, obs(), e); end
    end
    tick();
    e = beat(0, 3, 0, 0, 49, 305);
    checks++; if (obs() !== e) begin errors++; $display("FAIL rr_end_bubble: got %h expected %h", obs(), e); end
  endtask

  task automatic test_full();
    logic [70:0] e;
    int xs[4];
    xs = '{41, 42, 43, 99};
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 40 + i, 40 + i + 256, 1, 2);
      tick();
    end
    checks++; if (occ !== {3'd0, 3'd0, 3'd4, 3'd0}) begin errors++; $display("FAIL full_occ: got %h expected %h", occ, {3'd0, 3'd0, 3'd4, 3'd0}); end
    drive(1, 1, 99, 99 + 256, 3, 3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_t1: got %b expected 0", in_ready); end
    tick();
    checks++; if (occ !== {3'd0, 3'd0, 3'd4, 3'd0}) begin errors++; $display("FAIL full_drop: got %h expected %h", occ, {3'd0, 3'd0, 3'd4, 3'd0}); end
    in_valid  = 1'b0;
    in_thread = 2'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_t0: got %b expected 1", in_ready); end
    drive(1, 1, 99, 99 + 256, 3, 3);
    stall = 1'b0;
    tick();
    e = beat(1, 1, 1, 2, 40, 296);
    checks++; if (obs() !== e) begin errors++; $display("FAIL full_pop: got %h expected %h", obs(), e); end
    checks++; if (occ !== {3'd0, 3'd0, 3'd3, 3'd0}) begin errors++; $display("FAIL full_pop_occ: got %h expected %h", occ, {3'd0, 3'd0, 3'd3, 3'd0}); end
    stall = 1'b1;
    tick();
    checks++; if (occ !== {3'd0, 3'd0, 3'd4, 3'd0}) begin errors++; $display("FAIL full_accept: got %h expected %h", occ, {3'd0, 3'd0, 3'd4, 3'd0}); end
    drive(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = (k == 3) ? beat(1, 1, 3, 3, 99, 355) : beat(1, 1, 1, 2, xs[k], xs[k] + 256);
      checks++; if (obs() !== e) begin errors++; $display("FAIL full_drain_%0d: got %h expected %h", k, obs(), e); end
    end
  endtask

  task automatic test_stall();
    logic [70:0] e, frozen;
    int et[6], ex[6];
    et = '{1, 2, 3, 0, 3, 3};
    ex = '{32'h20, 32'h30, 32'h40, 32'h11, 32'h41, 32'h42};
    do_reset();
    stall = 1'b1;
    drive(1, 0, 32'h10, 32'h110, 0, 0); tick();
    drive(1, 0, 32'h11, 32'h111, 0, 0); tick();
    drive(1, 1, 32'h20, 32'h120, 0, 0); tick();
    drive(1, 2, 32'h30, 32'h130, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    tick();
    frozen = beat(1, 0, 0, 0, 32'h10, 32'h110);
    checks++; if (obs() !== frozen) begin errors++; $display("FAIL stall_first: got %h expected %h", obs(), frozen); end
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1, 3, 32'h40 + j, 32'h140 + j, 0, 0);
      tick();
      checks++; if (obs() !== frozen) begin errors++; $display("FAIL stall_frozen_%0d: got %h expected %h", j, obs(), frozen); end
    end
    checks++; if (occ !== {3'd3, 3'd1, 3'd1, 3'd1}) begin errors++; $display("FAIL stall_occ: got %h expected %h", occ, {3'd3, 3'd1, 3'd1, 3'd1}); end
    drive(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = beat(1, et[k], 0, 0, ex[k], ex[k] + 256);
      checks++; if (obs() !== e) begin errors++; $display("FAIL stall_resume_%0d: got %h expected %h", k, obs(), e); end
    end
    tick();
    e = beat(0, 3, 0, 0, 32'h42, 32'h142);
    checks++; if (obs() !== e) begin errors++; $display("FAIL stall_drained: got %h expected %h", obs(), e); end
    checks++; if (occ !== 12'd0) begin errors++; $display("FAIL stall_drained_occ: got %h expected 0", occ); end
  endtask

  task automatic test_back_to_back();
    logic [70:0] e;
    int k;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      k = n - 1;
      drive(1, 3, 200 + k, 300 + k, k % 4, 3 - (k % 4));
      tick();
      if (n == 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid: got %b expected 0", out_valid); end
      end else begin
        k = n - 2;
        e = beat(1, 3, k % 4, 3 - (k % 4), 200 + k, 300 + k);
        checks++; if (obs() !== e) begin errors++; $display("FAIL b2b_issue_%0d: got %h expected %h", n, obs(), e); end
      end
      checks++; if (occ !== {3'd1, 3'd0, 3'd0, 3'd0}) begin errors++; $display("FAIL b2b_occ_%0d: got %h expected %h", n, occ, {3'd1, 3'd0, 3'd0, 3'd0}); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    e = beat(1, 3, 1, 2, 209, 309);
    checks++; if (obs() !== e) begin errors++; $display("FAIL b2b_last: got %h expected %h", obs(), e); end
    tick();
    e = beat(0, 3, 0, 0, 209, 309);
    checks++; if (obs() !== e) begin errors++; $display("FAIL b2b_bubble: got %h expected %h", obs(), e); end
  endtask

  task automatic test_async_reset();
    logic [70:0] e;
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin drive(1, 0, 32'h50 + i, 32'h150 + i, 0, 0); tick(); end
    drive(1, 2, 32'h60, 32'h160, 0, 0); tick();
    drive(1, 3, 32'h70, 32'h170, 0, 0); tick();
    drive(1, 3, 32'h71, 32'h171, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    tick();
    e = beat(1, 0, 0, 0, 32'h50, 32'h150);
    checks++; if (obs() !== e) begin errors++; $display("FAIL arst_pre_issue: got %h expected %h", obs(), e); end
    checks++; if (occ !== {3'd2, 3'd1, 3'd0, 3'd3}) begin errors++; $display("FAIL arst_pre_occ: got %h expected %h", occ, {3'd2, 3'd1, 3'd0, 3'd3}); end
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (obs() !== 71'd0) begin errors++; $display("FAIL arst_outputs: got %h expected 0", obs()); end
    checks++; if (occ !== 12'd0) begin errors++; $display("FAIL arst_occ: got %h expected 0", occ); end
    #1;
    rstn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (obs() !== 71'd0) begin errors++; $display("FAIL arst_idle_%0d: got %h expected 0", j, obs()); end
    end
    drive(1, 2, 32'h99, 32'h199, 2, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    e = beat(1, 2, 2, 1, 32'h99, 32'h199);
    checks++; if (obs() !== e) begin errors++; $display("FAIL arst_new_push: got %h expected %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
